// File: rtl/dual_req_scheduler.sv
// Round-robin scheduler sharing one multi-cycle compute unit between two requesters.
// Optional per-requester accept counters are enabled with the SCHED_STATS_EN macro.
module dual_req_scheduler #(
    parameter int DW      = 2,
    parameter int RW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d1_valid,
    input  logic [DW-1:0] d1,
    output logic          d1_ready,
    input  logic          d2_valid,
    input  logic [DW-1:0] d2,
    output logic          d2_ready,
    output logic          unit_start,
    output logic [DW-1:0] unit_operand,
    input  logic          unit_done,
    input  logic [RW-1:0] unit_result,
    output logic [RW-1:0] q1,
    output logic [RW-1:0] q2,
    output logic          q1_valid,
    output logic          q2_valid,
    output logic          timeout_err,
    output logic          busy
`ifdef SCHED_STATS_EN
    ,
    output logic [7:0]    grants1,
    output logic [7:0]    grants2
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       last_grant2;   // 1: requester 2 was granted last
    logic [7:0] wait_cnt;
    logic       err_flag;
    logic       grant1, grant2;
    logic       accept;

    // Grant is only offered in IDLE; on a tie the requester not granted last wins.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (state == S_IDLE) begin
            if (d1_valid && d2_valid) begin
                grant1 = last_grant2;
                grant2 = !last_grant2;
            end else begin
                grant1 = d1_valid;
                grant2 = d2_valid;
            end
        end
    end

    assign accept = grant1 || grant2;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (unit_done || wait_cnt == LAST_CNT) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        d1_ready    = grant1;
        d2_ready    = grant2;
        unit_start  = (state == S_ISSUE);
        busy        = (state != S_IDLE);
        q1_valid    = (state == S_RESP) && !last_grant2;
        q2_valid    = (state == S_RESP) && last_grant2;
        timeout_err = (state == S_RESP) && err_flag;
    end

    // The result lands in q at the WAIT exit so it is visible alongside the valid pulse in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant2  <= 1'b1;
            unit_operand <= '0;
            wait_cnt     <= '0;
            err_flag     <= 1'b0;
            q1           <= '0;
            q2           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        unit_operand <= grant1 ? d1 : d2;
                        last_grant2  <= grant2;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    err_flag <= 1'b0;
                end
                S_WAIT: begin
                    if (unit_done) begin
                        if (last_grant2) q2 <= unit_result;
                        else             q1 <= unit_result;
                        err_flag <= 1'b0;
                    end else if (wait_cnt == LAST_CNT) begin
                        if (last_grant2) q2 <= '1;
                        else             q1 <= '1;
                        err_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grants1 <= '0;
            grants2 <= '0;
        end else begin
            if (grant1 && grants1 != 8'hFF) grants1 <= grants1 + 8'd1;
            if (grant2 && grants2 != 8'hFF) grants2 <= grants2 + 8'd1;
        end
    end
`endif

endmodule
